// File: rtl/enc_pkg.sv
// Shared definitions for the serial 8-to-3 index encoder.
package enc_pkg;

  localparam int unsigned N_IN  = 8;
  localparam int unsigned IDX_W = $clog2(N_IN);

  typedef logic [N_IN-1:0]  vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc_8x3.sv
// Lowest-set-bit priority encoder with a one-hot detector.
module prio_enc_8x3
  import enc_pkg::*;
(
  input  vec_t vec,
  output idx_t idx,
  output logic single
);

  // Scan from the top down so the lowest set bit is the last (winning) write.
  always_comb begin
    idx = '0;
    for (int unsigned i = N_IN; i > 0; i--) begin
      if (vec[i-1]) idx = idx_t'(i - 1);
    end
  end

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
  always_comb begin
    single = (vec != '0) && ((vec & (vec - vec_t'(1))) == '0);
  end

endmodule

// File: rtl/seq_encoder_8x3.sv
// Serial 8-to-3 index encoder: emits the index of every set request bit,
// lowest first, one per idx handshake.
module seq_encoder_8x3
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  req,
  input  logic             req_valid,
  output logic             req_ready,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic             idx_last,
  output logic             zero_err
);

  state_t state;
  vec_t   pending;
  idx_t   low_idx;
  logic   low_single;

  prio_enc_8x3 u_prio (
    .vec    (pending),
    .idx    (low_idx),
    .single (low_single)
  );

  // Outputs come only from registered state, so no input reaches them combinationally.
  always_comb begin
    req_ready = (state == IDLE);
    idx_valid = (state == EMIT);
    idx       = low_idx;
    idx_last  = low_single;
  end

  // Handshake FSM: load a vector in IDLE, retire one set bit per taken idx in EMIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= '0;
      zero_err <= 1'b0;
    end else begin
      zero_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req != '0) begin
              pending <= req;
              state   <= EMIT;
            end else begin
              zero_err <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (idx_ready) begin
            // Clearing the lowest set bit is the same bit that low_idx points at.
            pending <= pending & (pending - vec_t'(1));
            if (low_single) begin
              pending <= '0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

endmodule
